cond_gen_arbiter: RTL and testbench
===================================

Name: cond_gen_arbiter

Overview:
- Grants exclusive write access to one shared DATA_W-bit register among NUM_REQ requesters.
- The arbitration policy is chosen at elaboration by a generate-if on ARB_MODE: fixed priority or round-robin.
- A hold counter bounds grant tenure; one forced idle cycle follows each timeout.
- Sits between per-branch producers and the single shared storage element they contend for.

Parameters:
- NUM_REQ, 3, number of requesters; legal range 2..8.
- DATA_W, 32, width of each write datum and of the shared register.
- ARB_MODE, 0, policy: 0 = fixed priority (index 0 highest); 1 = round-robin. Any other value is an elaboration error.
- MAX_HOLD, 15, maximum consecutive granted cycles per tenure; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_i  input  NUM_REQ  per-requester request; level, held while access is wanted.
- wdata_i  input  NUM_REQ*DATA_W  per-requester write data; slice k = bits [k*DATA_W +: DATA_W].
- gnt_o  output  NUM_REQ  one-hot (or zero) registered grant.
- shared_q_o  output  DATA_W  shared register contents.
- wr_pulse_o  output  1  high for one cycle after each cycle in which shared_q_o was written.
- timeout_o  output  1  high during the forced idle cycle that follows a hold expiry.
- busy_o  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values (all asynchronous on rst_n low):
  - state = IDLE; gnt_o = 0; shared_q_o = 0; wr_pulse_o = 0; timeout_o = 0; busy_o = 0.
  - hold counter = 0; round-robin pointer = 0.
- States: IDLE, GRANT, COOL. All outputs are registered.
- IDLE:
  - If req_i is nonzero, select winner w, set gnt_o = 1<<w, load counter = 1, go to GRANT.
  - Grant latency is one clock from req assertion.
- Winner selection:
  - ARB_MODE 0: lowest set index of req_i.
  - ARB_MODE 1: first set index at or after the pointer, wrapping modulo NUM_REQ. The pointer loads (w+1) mod NUM_REQ when the grant is issued.
- GRANT with holder g:
  - While req_i[g] = 1: shared_q_o <= wdata_i slice g and wr_pulse_o <= 1 on every such edge.
  - If req_i[g] = 1 and counter == MAX_HOLD: that final write still occurs; gnt_o <= 0, timeout_o <= 1, go to COOL.
  - Else if req_i[g] = 1: counter increments.
  - If req_i[g] = 0: no write, wr_pulse_o <= 0, gnt_o <= 0, go to IDLE.
  - Requests from non-holders are ignored; preemption never occurs.
- COOL:
  - Lasts exactly one cycle with no grant and no write, then goes to IDLE.
  - timeout_o clears on leaving COOL.
- Write rules:
  - wr_pulse_o is 0 in IDLE and COOL.
  - shared_q_o holds its value whenever no write occurs.
  - The maximum number of writes per tenure is MAX_HOLD.
- Counter width is clog2(MAX_HOLD+1). The counter never wraps; it is bounded by the expiry rule.
- Simultaneous events:
  - Holder drops req in the same cycle another requester rises: go to IDLE first; the new grant issues the cycle after. Minimum gap between grants is one cycle.
  - Requests arriving during COOL are served from IDLE.
- Round-robin with a single requester: the same requester is re-granted after each COOL or IDLE gap.
- Reset asserted mid-tenure: every output is immediately at its reset value and the pointer clears. No write completes after rst_n falls.
- The gnt_o one-hot property holds in every cycle.

Test Plan:
- Reset mid-tenure:
  - Stimulus: ARB_MODE=0, req_i=3'b010 held, rst_n low in cycle 3.
  - Required: gnt_o=3'b010 one cycle after req; on reset, gnt_o, shared_q_o and busy_o go to 0 asynchronously.
- Fixed-priority contention:
  - Stimulus: ARB_MODE=0, req_i=3'b111 held for 4 cycles then released; wdata slices 0xA0, 0xB1, 0xC2.
  - Required: gnt_o=3'b001 only; shared_q_o=0xA0; 4 wr_pulse_o cycles; then IDLE.
- Round-robin rotation:
  - Stimulus: ARB_MODE=1, all three requesters assert and each drops 2 cycles after its grant.
  - Required: grant order 0, 1, 2, 0; one idle cycle between grants.
- Hold expiry:
  - Stimulus: MAX_HOLD=4, req_i[1] held for 20 cycles.
  - Required: 4 writes; timeout_o=1 for exactly one cycle with gnt_o=0; regrant to index 1 two cycles after expiry; pattern repeats.
- Simultaneous drop and new request:
  - Stimulus: holder 0 drops its req in the same cycle req_i[2] rises.
  - Required: one cycle IDLE with gnt_o=0, then gnt_o=3'b100; shared_q_o unchanged during the gap.
- Per-requester data path:
  - Stimulus: DATA_W=8, NUM_REQ=2, wdata changing every cycle under grant.
  - Required: shared_q_o tracks the holder's slice with a one-cycle lag; the other slice is never written.

Source files
------------

// File: rtl/cond_gen_arbiter.sv
// Shared-register write arbiter, fixed-priority or round-robin policy.
// Ports: clk, rst_n, req_i, wdata_i -> gnt_o, shared_q_o, wr_pulse_o, timeout_o, busy_o.
module cond_gen_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0,
    parameter int MAX_HOLD = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [DATA_W-1:0]           shared_q_o,
    output logic                        wr_pulse_o,
    output logic                        timeout_o,
    output logic                        busy_o
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam int PW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_COOL  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [DATA_W-1:0]  shared_q, shared_d;
    logic               wr_pulse_q, wr_pulse_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [PW-1:0]      win_idx;
    logic               win_vld;
    logic               hold_req;
    logic [DATA_W-1:0]  hold_data;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 1 || MAX_HOLD > 255 ||
            (ARB_MODE != 0 && ARB_MODE != 1)) begin : g_bad_param
            $error("cond_gen_arbiter: illegal parameter value");
        end

        if (ARB_MODE == 0) begin : g_fixed
            // Descending scan so the lowest set index wins.
            always_comb begin
                win_idx = '0;
                win_vld = 1'b0;
                for (int i = NUM_REQ - 1; i >= 0; i--) begin
                    if (req_i[i]) begin
                        win_idx = PW'(i);
                        win_vld = 1'b1;
                    end
                end
            end
        end else begin : g_rr
            logic [PW-1:0] ptr_q, ptr_d;
            logic [PW-1:0] j;

            // First requester at or after the pointer, wrapping.
            always_comb begin
                win_idx = '0;
                win_vld = 1'b0;
                j       = '0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    j = PW'((int'(ptr_q) + i) % NUM_REQ);
                    if (!win_vld && req_i[j]) begin
                        win_idx = j;
                        win_vld = 1'b1;
                    end
                end
            end

            always_comb begin
                ptr_d = ptr_q;
                if (state_q == S_IDLE && win_vld) begin
                    ptr_d = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) ptr_q <= '0;
                else        ptr_q <= ptr_d;
            end
        end
    endgenerate

    // Holder's request level and write slice, selected by the one-hot grant.
    always_comb begin
        hold_req  = |(req_i & gnt_q);
        hold_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_q[k]) hold_data = wdata_i[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        shared_d   = shared_q;
        wr_pulse_d = 1'b0;
        timeout_d  = 1'b0;
        cnt_d      = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    cnt_d   = CW'(1);
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (hold_req) begin
                    shared_d   = hold_data;
                    wr_pulse_d = 1'b1;
                    if (cnt_q == CW'(MAX_HOLD)) begin
                        gnt_d     = '0;
                        timeout_d = 1'b1;
                        state_d   = S_COOL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            shared_q   <= '0;
            wr_pulse_q <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            shared_q   <= shared_d;
            wr_pulse_q <= wr_pulse_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign shared_q_o = shared_q;
    assign wr_pulse_o = wr_pulse_q;
    assign timeout_o  = timeout_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_cond_gen_arbiter.sv
// Scoreboard bench for cond_gen_arbiter across three parameterisations.
// Ports: drives req/wdata per instance, checks all outputs each cycle.
module tb_cond_gen_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  fp_req = '0, rr_req = '0;
    logic [1:0]  dp_req = '0;
    logic [95:0] fp_wd = '0, rr_wd = '0;
    logic [15:0] dp_wd = '0;

    logic [2:0]  fp_gnt, rr_gnt;
    logic [1:0]  dp_gnt;
    logic [31:0] fp_sh, rr_sh;
    logic [7:0]  dp_sh;
    logic        fp_wr, fp_to, fp_bz;
    logic        rr_wr, rr_to, rr_bz;
    logic        dp_wr, dp_to, dp_bz;

    cond_gen_arbiter #(.NUM_REQ(3), .DATA_W(32), .ARB_MODE(0), .MAX_HOLD(15)) u_fp (
        .clk(clk), .rst_n(rst_n), .req_i(fp_req), .wdata_i(fp_wd),
        .gnt_o(fp_gnt), .shared_q_o(fp_sh), .wr_pulse_o(fp_wr),
        .timeout_o(fp_to), .busy_o(fp_bz));

    cond_gen_arbiter #(.NUM_REQ(3), .DATA_W(32), .ARB_MODE(1), .MAX_HOLD(4)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_i(rr_req), .wdata_i(rr_wd),
        .gnt_o(rr_gnt), .shared_q_o(rr_sh), .wr_pulse_o(rr_wr),
        .timeout_o(rr_to), .busy_o(rr_bz));

    cond_gen_arbiter #(.NUM_REQ(2), .DATA_W(8), .ARB_MODE(0), .MAX_HOLD(15)) u_dp (
        .clk(clk), .rst_n(rst_n), .req_i(dp_req), .wdata_i(dp_wd),
        .gnt_o(dp_gnt), .shared_q_o(dp_sh), .wr_pulse_o(dp_wr),
        .timeout_o(dp_to), .busy_o(dp_bz));

    typedef struct {
        int          d;
        string       nm;
        logic [2:0]  gnt;
        logic        wr;
        logic        to;
        logic        bz;
        logic [31:0] sh;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic get_out(input int d, output logic [2:0] g, output logic w,
                           output logic t, output logic b, output logic [31:0] s);
        case (d)
            0: begin g = fp_gnt; w = fp_wr; t = fp_to; b = fp_bz; s = fp_sh; end
            1: begin g = rr_gnt; w = rr_wr; t = rr_to; b = rr_bz; s = rr_sh; end
            default: begin
                g = {1'b0, dp_gnt}; w = dp_wr; t = dp_to; b = dp_bz; s = {24'h0, dp_sh};
            end
        endcase
    endtask

    // Monitor: one expectation per clock, checked 1 time unit after the edge.
    always @(posedge clk) begin
        exp_t        e;
        logic [2:0]  g;
        logic        w, t, b;
        logic [31:0] s;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            get_out(e.d, g, w, t, b, s);
            chk({e.nm, "_gnt"}, 32'(g), 32'(e.gnt));
            chk({e.nm, "_wr"},  32'(w), 32'(e.wr));
            chk({e.nm, "_to"},  32'(t), 32'(e.to));
            chk({e.nm, "_busy"}, 32'(b), 32'(e.bz));
            chk({e.nm, "_sh"},  s, e.sh);
            chk({e.nm, "_onehot"}, 32'($onehot0(g)), 32'd1);
        end
    end

    // Apply req at a falling edge, queue the response after the next rising edge.
    task automatic step(input int d, input logic [2:0] req, input logic [2:0] g,
                        input logic w, input logic t, input logic b,
                        input logic [31:0] s, input string nm);
        exp_t e;
        fp_req = (d == 0) ? req : 3'b000;
        rr_req = (d == 1) ? req : 3'b000;
        dp_req = (d == 2) ? req[1:0] : 2'b00;
        e.d = d; e.nm = nm; e.gnt = g; e.wr = w; e.to = t; e.bz = b; e.sh = s;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        fp_wd = {32'hC2, 32'hB1, 32'hA0};
        rr_wd = {32'h33, 32'h22, 32'h11};
        #1;
        chk("rst_fp_gnt", 32'(fp_gnt), 0);
        chk("rst_fp_sh", fp_sh, 0);
        chk("rst_fp_flags", {29'h0, fp_wr, fp_to, fp_bz}, 0);
        chk("rst_rr_all", {rr_gnt, rr_wr, rr_to, rr_bz}, 0);
        chk("rst_dp_all", {dp_gnt, dp_wr, dp_to, dp_bz}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-tenure
        step(0, 3'b010, 3'b010, 0, 0, 1, 32'h0,  "rm_grant");
        step(0, 3'b010, 3'b010, 1, 0, 1, 32'hB1, "rm_write");
        rst_n = 1'b0;
        #1;
        chk("rm_async_gnt", 32'(fp_gnt), 0);
        chk("rm_async_sh", fp_sh, 0);
        chk("rm_async_busy", 32'(fp_bz), 0);
        chk("rm_async_wr", 32'(fp_wr), 0);
        @(negedge clk);
        fp_req = '0;
        rst_n  = 1'b1;
        @(negedge clk);

        // Fixed-priority contention: 4 writes by requester 0
        step(0, 3'b111, 3'b001, 0, 0, 1, 32'h0,  "fp_grant");
        for (int i = 0; i < 4; i++)
            step(0, 3'b111, 3'b001, 1, 0, 1, 32'hA0, "fp_write");
        step(0, 3'b000, 3'b000, 0, 0, 0, 32'hA0, "fp_drop");
        step(0, 3'b000, 3'b000, 0, 0, 0, 32'hA0, "fp_idle");

        // Round-robin rotation 0,1,2,0
        step(1, 3'b111, 3'b001, 0, 0, 1, 32'h0,  "rr_g0");
        step(1, 3'b111, 3'b001, 1, 0, 1, 32'h11, "rr_w0");
        step(1, 3'b110, 3'b000, 0, 0, 0, 32'h11, "rr_d0");
        step(1, 3'b110, 3'b010, 0, 0, 1, 32'h11, "rr_g1");
        step(1, 3'b110, 3'b010, 1, 0, 1, 32'h22, "rr_w1");
        step(1, 3'b100, 3'b000, 0, 0, 0, 32'h22, "rr_d1");
        step(1, 3'b101, 3'b100, 0, 0, 1, 32'h22, "rr_g2");
        step(1, 3'b101, 3'b100, 1, 0, 1, 32'h33, "rr_w2");
        step(1, 3'b001, 3'b000, 0, 0, 0, 32'h33, "rr_d2");
        step(1, 3'b001, 3'b001, 0, 0, 1, 32'h33, "rr_g0b");
        step(1, 3'b001, 3'b001, 1, 0, 1, 32'h11, "rr_w0b");
        step(1, 3'b000, 3'b000, 0, 0, 0, 32'h11, "rr_d0b");

        // Hold expiry with MAX_HOLD=4, single requester 1
        step(1, 3'b010, 3'b010, 0, 0, 1, 32'h11, "hx_grant");
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++)
                step(1, 3'b010, 3'b010, 1, 0, 1, 32'h22, "hx_write");
            step(1, 3'b010, 3'b000, 1, 1, 1, 32'h22, "hx_expire");
            step(1, 3'b010, 3'b000, 0, 0, 0, 32'h22, "hx_cool");
            step(1, 3'b010, 3'b010, 0, 0, 1, 32'h22, "hx_regrant");
        end
        step(1, 3'b000, 3'b000, 0, 0, 0, 32'h22, "hx_drop");

        // Holder drops while another request rises
        fp_wd[31:0] = 32'h5A0;
        step(0, 3'b001, 3'b001, 0, 0, 1, 32'hA0,  "sd_grant");
        step(0, 3'b001, 3'b001, 1, 0, 1, 32'h5A0, "sd_write");
        step(0, 3'b100, 3'b000, 0, 0, 0, 32'h5A0, "sd_gap");
        step(0, 3'b100, 3'b100, 0, 0, 1, 32'h5A0, "sd_grant2");
        step(0, 3'b100, 3'b100, 1, 0, 1, 32'hC2,  "sd_write2");
        step(0, 3'b000, 3'b000, 0, 0, 0, 32'hC2,  "sd_idle");

        // Per-requester data path, 2 x 8-bit
        dp_wd = {8'h10, 8'hE0};
        step(2, 3'b010, 3'b010, 0, 0, 1, 32'h0, "dp_grant");
        for (int i = 0; i < 4; i++) begin
            dp_wd = {8'(8'h20 + i), 8'(8'hF0 + i)};
            step(2, 3'b011, 3'b010, 1, 0, 1, 32'(8'h20 + i), "dp_write");
        end
        step(2, 3'b000, 3'b000, 0, 0, 0, 32'h23, "dp_drop");

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(sbq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
